// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding and frame constants.
// The transmit side will import the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam int unsigned NUM_BITS = 8;
  localparam logic [15:0] MIN_CLKS = 16'd2;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous level.
// Resets to 1, which is the idle level of a UART line.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_D,
  output logic o_Q
);

  logic [SYNC_STAGES-1:0] q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) q <= '1;
    else       q <= {q[SYNC_STAGES-2:0], i_D};
  end

  assign o_Q = q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-entry holding register,
// valid/ack handshake and sticky framing-error / overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_UART_RX,
  input  logic [15:0] i_ClksPerBit,
  output logic [7:0]  o_Data,
  output logic        o_Valid,
  input  logic        i_Ack,
  input  logic        i_ClrErr,
  output logic        o_FrameErr,
  output logic        o_Overrun,
  output logic        o_Busy
);

  logic        rx_s;
  rx_state_e   state, state_nxt;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic [15:0] half, last;
  logic        en, half_hit, bit_hit;
  logic        cnt_run, tick, shift;
  logic        deliver, ferr;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_D  (i_UART_RX),
    .o_Q  (rx_s)
  );

  assign en       = i_ClksPerBit >= MIN_CLKS;
  assign half     = (i_ClksPerBit - 16'd1) >> 1;
  assign last     = i_ClksPerBit - 16'd1;
  assign half_hit = cnt >= half;
  assign bit_hit  = cnt >= last;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Dropping below the minimum bit period aborts any frame.
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (!rx_s) state_nxt = START;
        START: if (half_hit) state_nxt = rx_s ? IDLE : DATA;
        DATA:  if (bit_hit && idx == 3'(NUM_BITS - 1))
                 state_nxt = STOP;
        STOP:  if (bit_hit) state_nxt = rx_s ? IDLE : BREAK;
        BREAK: if (rx_s) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_run = 1'b0;
    tick    = 1'b0;
    shift   = 1'b0;
    deliver = 1'b0;
    ferr    = 1'b0;
    o_Busy  = state != IDLE;
    if (en) begin
      unique case (state)
        START: begin
          cnt_run = 1'b1;
          tick    = half_hit;
        end
        DATA: begin
          cnt_run = 1'b1;
          tick    = bit_hit;
          shift   = bit_hit;
        end
        STOP: begin
          cnt_run = 1'b1;
          tick    = bit_hit;
          deliver = bit_hit & rx_s;
          ferr    = bit_hit & ~rx_s;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      cnt <= (cnt_run && !tick) ? cnt + 16'd1 : '0;
      if (shift) begin
        shreg <= {rx_s, shreg[7:1]};
        idx   <= idx + 3'd1;
      end else if (state != DATA) begin
        idx <= '0;
      end
    end
  end

  // Set events take priority over the error clear.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Data     <= '0;
      o_Valid    <= 1'b0;
      o_FrameErr <= 1'b0;
      o_Overrun  <= 1'b0;
    end else begin
      if (deliver && (!o_Valid || i_Ack)) begin
        o_Data  <= shreg;
        o_Valid <= 1'b1;
      end else if (i_Ack) begin
        o_Valid <= 1'b0;
      end
      if (deliver && o_Valid && !i_Ack) o_Overrun <= 1'b1;
      else if (i_ClrErr)                o_Overrun <= 1'b0;
      if (ferr)          o_FrameErr <= 1'b1;
      else if (i_ClrErr) o_FrameErr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of good frames plus
// hand-written glitch, framing, overrun, disable and reset cases.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst, rx, ack, clr;
  logic [15:0] cpb;
  logic [7:0]  data;
  logic        valid, ferr, ovr, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         c;
    logic [7:0] d;
    int         exp_rise;
  } vec_t;

  vec_t tbl[6];

  uart_rx #(
    .SYNC_STAGES(2)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_UART_RX   (rx),
    .i_ClksPerBit(cpb),
    .o_Data      (data),
    .o_Valid     (valid),
    .i_Ack       (ack),
    .i_ClrErr    (clr),
    .o_FrameErr  (ferr),
    .o_Overrun   (ovr),
    .o_Busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
  endtask

  // Drives n cycles of a frame with bit width bw; cycle k=0 is
  // the first start-bit cycle. rise is the first cycle index at
  // which o_Valid reads 1.
  task automatic send(input int bw, input logic [7:0] d,
                      input logic sb, input logic tail,
                      input int n, input int ack_k,
                      input int rst_k, output int rise,
                      output logic busy_seen);
    logic [9:0] fr;
    fr = {sb, d, 1'b0};
    rise = -1;
    busy_seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      rx  = (k < 10 * bw) ? fr[k / bw] : tail;
      ack = (k == ack_k);
      rst = (k == rst_k);
      @(posedge clk);
      #1;
      busy_seen |= busy;
      if (valid && rise < 0) rise = k + 1;
    end
    ack = 1'b0;
    rst = 1'b0;
    rx  = tail;
  endtask

  int   rise;
  logic bs;

  initial begin
    tbl[0] = '{4,  8'hA5, 41};
    tbl[1] = '{5,  8'h00, 51};
    tbl[2] = '{6,  8'hFF, 60};
    tbl[3] = '{2,  8'h81, 22};
    tbl[4] = '{3,  8'h5A, 32};
    tbl[5] = '{16, 8'h3C, 155};

    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    clr = 1'b0;
    cpb = 16'd4;
    idle(3);
    rst = 1'b0;
    idle(50);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_busy", busy, 0);

    foreach (tbl[i]) begin
      cpb = 16'(tbl[i].c);
      idle(4);
      send(tbl[i].c, tbl[i].d, 1'b1, 1'b1,
           tbl[i].exp_rise + 4, -1, -1, rise, bs);
      chk($sformatf("v%0d_rise", i), rise, tbl[i].exp_rise);
      chk($sformatf("v%0d_data", i), data, tbl[i].d);
      pulse_ack();
      chk($sformatf("v%0d_ack", i), valid, 0);
    end

    // Glitch: two low cycles at C=8.
    cpb = 16'd8;
    idle(4);
    bs = 1'b0;
    rx = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idle(1);
      bs |= busy;
    end
    rx = 1'b1;
    for (int k = 0; k < 12; k++) begin
      idle(1);
      bs |= busy;
    end
    chk("gl_busy_seen", bs, 1);
    chk("gl_busy_end", busy, 0);
    chk("gl_valid", valid, 0);
    chk("gl_flags", {ferr, ovr}, 0);

    // Framing error then line held low.
    cpb = 16'd4;
    idle(4);
    send(4, 8'h3C, 1'b0, 1'b0, 76, -1, -1, rise, bs);
    chk("fe_ferr", ferr, 1);
    chk("fe_valid", valid, 0);
    chk("fe_break", busy, 1);
    rx = 1'b1;
    idle(5);
    chk("fe_idle", busy, 0);
    send(4, 8'h5A, 1'b1, 1'b1, 44, -1, -1, rise, bs);
    chk("fe_next_data", data, 8'h5A);
    chk("fe_next_valid", valid, 1);
    pulse_ack();
    pulse_clr();
    chk("fe_clr", ferr, 0);

    // Overrun, clear, then same-cycle ack on delivery.
    idle(4);
    send(4, 8'h11, 1'b1, 1'b1, 44, -1, -1, rise, bs);
    send(4, 8'h22, 1'b1, 1'b1, 44, -1, -1, rise, bs);
    chk("ov_data", data, 8'h11);
    chk("ov_flag", ovr, 1);
    chk("ov_valid", valid, 1);
    pulse_clr();
    chk("ov_clr", ovr, 0);
    send(4, 8'h33, 1'b1, 1'b1, 44, 40, -1, rise, bs);
    chk("sa_data", data, 8'h33);
    chk("sa_valid", valid, 1);
    chk("sa_ovr", ovr, 0);
    pulse_ack();
    chk("sa_ack", valid, 0);

    // Receiver disabled with C=0.
    cpb = 16'd0;
    idle(4);
    send(4, 8'h55, 1'b1, 1'b1, 44, -1, -1, rise, bs);
    chk("dis_busy", bs, 0);
    chk("dis_valid", valid, 0);

    // Reset at data bit 3 with a byte pending.
    cpb = 16'd4;
    idle(4);
    send(4, 8'h42, 1'b1, 1'b1, 44, -1, -1, rise, bs);
    chk("pre_rst_valid", valid, 1);
    send(4, 8'h99, 1'b1, 1'b1, 19, -1, 18, rise, bs);
    chk("mr_busy_seen", bs, 1);
    chk("mr_busy", busy, 0);
    chk("mr_valid", valid, 0);
    chk("mr_data", data, 0);
    chk("mr_flags", {ferr, ovr}, 0);
    idle(20);
    send(4, 8'h7E, 1'b1, 1'b1, 44, -1, -1, rise, bs);
    chk("mr_next_rise", rise, 41);
    chk("mr_next_data", data, 8'h7E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
